mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle decoder once the datapath shares one memory port and one ALU across cycles.
- Decodes the instruction register contents and walks a Moore FSM (Mealy only on memory handshake strobes) through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select, write enable, ALU operation and PC update.
- Sits between the instruction register/memory port and the register file/ALU/PC.

Parameters:
- NOP_FAST, 1, when 1 an all-zero instruction returns DECODE->FETCH directly; when 0 it runs through RTYPE_EX/RTYPE_WB with reg_write suppressed.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; state to FETCH
- inst  in  32  instruction register output; op = inst[31:26], funct = inst[5:0]
- mem_ready  in  1  memory port completes the current read/write this cycle
- syscall_done  in  1  syscall handler finished
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition true
- branch_ne  out  1  condition select: 0 = BEQ (zero), 1 = BNE (!zero)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- reg_dst  out  2  write register: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 lui
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs
- syscall_req  out  1  syscall pending
- illegal  out  1  sticky undefined-instruction flag
- state  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - state = FETCH (0); illegal = 0.
  - While reset is high, every strobe output (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, syscall_req) is forced to 0. All selects are 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BRANCH 8, JUMP 9, IMM_EX 10, IMM_WB 11, SYSCALL 12, JR 13, JAL 14, HALT 15.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 010, pc_source = 00.
  - Holds while mem_ready = 0.
  - In the cycle mem_ready = 1: ir_write = 1 and pc_write = 1 (PC+4), then go to DECODE. Exactly one PC increment per fetch.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 010 (branch target into ALUOut).
  - LW/SW -> MEMADR.
  - SPECIAL: JR (001000) -> JR; SYSCALL (001100) -> SYSCALL; all-zero inst -> FETCH if NOP_FAST, else RTYPE_EX.
  - ADD/SUB/AND/OR/SLT -> RTYPE_EX.
  - BEQ/BNE -> BRANCH.
  - ADDI/ADDIU/ORI/LUI -> IMM_EX.
  - J -> JUMP.
  - JAL -> JAL.
  - Any other opcode or funct: set illegal, go to HALT.
- MEMADR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 010.
  - Next state: MEMRD if LW, MEMWR if SW.
- MEMRD: mem_read = 1, i_or_d = 1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_dst = 00, mem_to_reg = 01, reg_write = 1. Next state FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Holds until mem_ready, then FETCH. mem_write is deasserted in the cycle after mem_ready.
- RTYPE_EX:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op per funct (ADD 010, SUB 110, AND 000, OR 001, SLT 111).
  - Next state RTYPE_WB.
- RTYPE_WB: reg_dst = 01, mem_to_reg = 00, reg_write = 1. reg_write is 0 for the all-zero NOP. Next state FETCH.
- IMM_EX:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 010 (ADDI/ADDIU), 001 (ORI), 011 (LUI).
  - Next state IMM_WB.
- IMM_WB: reg_dst = 00, reg_write = 1. Next state FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_write_cond = 1, pc_source = 01, branch_ne = (op == BNE).
  - Next state FETCH.
- JUMP: pc_write = 1, pc_source = 10. Next state FETCH.
- JAL: reg_dst = 10, mem_to_reg = 10, reg_write = 1 (PC+4 into $31), pc_write = 1, pc_source = 10. Next state FETCH.
- JR: pc_write = 1, pc_source = 11. No register write. Next state FETCH.
- SYSCALL: syscall_req = 1. Holds until syscall_done = 1, then FETCH.
- HALT: all strobes 0; absorbing until reset.
- Boundary rules:
  - mem_ready or syscall_done asserted outside its waiting state is ignored.
  - Reset mid-wait (FETCH/MEMRD/MEMWR/SYSCALL) aborts immediately, with no stray write or pc_write.
  - inst is sampled only in DECODE and later states; it is not decoded in FETCH.

Optional Feature:
- Macro: MC_CONTROL_PERF_EN.
- With it defined, two extra 32-bit outputs are added:
  - cycle_count: increments every non-reset cycle, wraps at 2^32.
  - inst_retired: increments on every transition into FETCH from a non-FETCH, non-HALT state.
  - Both reset to 0.
- Without it, these ports and their logic are absent.

Test Plan:
- Reset released with mem_ready = 0 for 3 cycles, then 1 -> state = 0 for 4 cycles; mem_read = 1 throughout; ir_write and pc_write pulse exactly once, in cycle 4.
- inst = 0x8D090004 (LW), mem_ready = 1 always -> states 0,1,2,3,4,0; MEMWB shows reg_write = 1, mem_to_reg = 01, reg_dst = 00.
- inst = 0x01095020 (ADD) then 0x0109502A (SLT) -> RTYPE_EX alu_op = 010, then 111; RTYPE_WB reg_dst = 01 with one reg_write pulse per instruction.
- inst = 0x15090003 (BNE) -> BRANCH: pc_write_cond = 1, branch_ne = 1, alu_op = 110, pc_source = 01; inst = 0x0C000010 (JAL) -> reg_dst = 10, mem_to_reg = 10, pc_source = 10.
- inst = 0x0000000C (SYSCALL), syscall_done held 0 for 5 cycles -> syscall_req = 1 for those cycles; FETCH on the cycle after syscall_done = 1.
- inst = 0xFC000000 -> illegal = 1, state = 15 held; reset asserted mid-MEMWR -> mem_write drops to 0 immediately and state = 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control sequencer.
// Moore FSM over fetch/decode/execute/memory/writeback; the fetch strobes
// (ir_write, pc_write) are Mealy on mem_ready so each fetch increments PC once.
// Optional build macro MC_CONTROL_PERF_EN adds cycle_count and inst_retired.
module mc_control_fsm #(
    parameter bit NOP_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        syscall_done,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_ne,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        syscall_req,
    output logic        illegal,
`ifdef MC_CONTROL_PERF_EN
    output logic [3:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] inst_retired
`else
    output logic [3:0]  state
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD = 4'd3,
        MEMWB    = 4'd4,  MEMWR   = 4'd5,  RTYPE_EX = 4'd6, RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,  JUMP    = 4'd9,  IMM_EX  = 4'd10, IMM_WB = 4'd11,
        SYSCALL  = 4'd12, JR      = 4'd13, JAL     = 4'd14, HALT = 4'd15
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C, FN_ADD = 6'h20,
                           FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_SLT = 6'h2A;

    state_t     curState, nxtState;
    logic       illegalReg, setIllegal;
    logic [5:0] opCode, funct;
    logic       isNop;

    assign opCode  = inst[31:26];
    assign funct   = inst[5:0];
    assign isNop   = (inst == 32'h0);
    assign state   = curState;
    assign illegal = illegalReg;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) curState <= FETCH;
        else       curState <= nxtState;
    end

    // Sticky undefined-instruction flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           illegalReg <= 1'b0;
        else if (setIllegal) illegalReg <= 1'b1;
    end

    // Next-state and control outputs; everything held at 0 while reset is high.
    always_comb begin
        nxtState      = curState;
        setIllegal    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        syscall_req   = 1'b0;
        if (!reset) begin
            case (curState)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 3'b010;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxtState = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = 3'b010;
                    case (opCode)
                        OP_LW, OP_SW:                     nxtState = MEMADR;
                        OP_BEQ, OP_BNE:                   nxtState = BRANCH;
                        OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: nxtState = IMM_EX;
                        OP_J:                             nxtState = JUMP;
                        OP_JAL:                           nxtState = JAL;
                        OP_SPECIAL: begin
                            if (isNop) nxtState = NOP_FAST ? FETCH : RTYPE_EX;
                            else begin
                                case (funct)
                                    FN_JR:      nxtState = JR;
                                    FN_SYSCALL: nxtState = SYSCALL;
                                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:
                                                nxtState = RTYPE_EX;
                                    default: begin
                                        setIllegal = 1'b1;
                                        nxtState   = HALT;
                                    end
                                endcase
                            end
                        end
                        default: begin
                            setIllegal = 1'b1;
                            nxtState   = HALT;
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 3'b010;
                    nxtState  = (opCode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) nxtState = MEMWB;
                end
                MEMWB: begin
                    mem_to_reg = 2'b01;
                    reg_write  = 1'b1;
                    nxtState   = FETCH;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) nxtState = FETCH;
                end
                RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        FN_SUB:  alu_op = 3'b110;
                        FN_AND:  alu_op = 3'b000;
                        FN_OR:   alu_op = 3'b001;
                        FN_SLT:  alu_op = 3'b111;
                        default: alu_op = 3'b010;
                    endcase
                    nxtState = RTYPE_WB;
                end
                RTYPE_WB: begin
                    reg_dst   = 2'b01;
                    reg_write = !isNop;
                    nxtState  = FETCH;
                end
                IMM_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opCode)
                        OP_ORI:  alu_op = 3'b001;
                        OP_LUI:  alu_op = 3'b011;
                        default: alu_op = 3'b010;
                    endcase
                    nxtState = IMM_WB;
                end
                IMM_WB: begin
                    reg_write = 1'b1;
                    nxtState  = FETCH;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 3'b110;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = (opCode == OP_BNE);
                    nxtState      = FETCH;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    nxtState  = FETCH;
                end
                JAL: begin
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    nxtState   = FETCH;
                end
                JR: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b11;
                    nxtState  = FETCH;
                end
                SYSCALL: begin
                    syscall_req = 1'b1;
                    if (syscall_done) nxtState = FETCH;
                end
                default: nxtState = HALT;
            endcase
        end
    end

`ifdef MC_CONTROL_PERF_EN
    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count  <= 32'd0;
            inst_retired <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (nxtState == FETCH && curState != FETCH && curState != HALT)
                inst_retired <= inst_retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each scenario queues per-cycle stimulus
// with the expected outputs, then drives and compares cycle by cycle.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        mem_ready = 1'b0;
    logic        syscall_done = 1'b0;
    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic        ir_write, reg_write, alu_src_a, syscall_req, illegal;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [3:0]  state;
`ifdef MC_CONTROL_PERF_EN
    logic [31:0] cycle_count, inst_retired;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready),
        .syscall_done(syscall_done), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .syscall_req(syscall_req), .illegal(illegal),
`ifdef MC_CONTROL_PERF_EN
        .state(state), .cycle_count(cycle_count), .inst_retired(inst_retired)
`else
        .state(state)
`endif
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcW, pcWC, mrd, mwr, irw, rw, sreq;
        logic       ill, bne, iord;
        logic [1:0] rdst, m2r;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] psrc;
    } ctl_t;

    typedef struct {
        string tag;
        ctl_t  val;
        ctl_t  mask;
    } exp_t;

    typedef struct {
        logic        rst, mr, sd;
        logic [31:0] in;
    } stim_t;

    localparam logic [6:0] S_NONE = 7'b0000000, S_PCW = 7'b1000000,
                           S_PCWC = 7'b0100000, S_MRD = 7'b0010000,
                           S_MWR = 7'b0001000, S_IRW = 7'b0000100,
                           S_RW = 7'b0000010, S_SREQ = 7'b0000001;

    stim_t stimQ[$];
    exp_t  expQ[$];
    stim_t s;
    exp_t  e;
    ctl_t  got;

    function automatic ctl_t obs();
        ctl_t c;
        c.st = state; c.pcW = pc_write; c.pcWC = pc_write_cond; c.mrd = mem_read;
        c.mwr = mem_write; c.irw = ir_write; c.rw = reg_write; c.sreq = syscall_req;
        c.ill = illegal; c.bne = branch_ne; c.iord = i_or_d; c.rdst = reg_dst;
        c.m2r = mem_to_reg; c.asa = alu_src_a; c.asb = alu_src_b; c.aop = alu_op;
        c.psrc = pc_source;
        return c;
    endfunction

    // Expected state, strobes and illegal flag; selects added by the caller.
    function automatic exp_t ex(string tag, logic [3:0] st, logic [6:0] stb, logic ill);
        exp_t r;
        r.tag = tag; r.val = '0; r.mask = '0;
        r.val.st = st; r.mask.st = '1;
        {r.val.pcW, r.val.pcWC, r.val.mrd, r.val.mwr, r.val.irw, r.val.rw, r.val.sreq} = stb;
        {r.mask.pcW, r.mask.pcWC, r.mask.mrd, r.mask.mwr, r.mask.irw, r.mask.rw, r.mask.sreq} = 7'h7F;
        r.val.ill = ill; r.mask.ill = 1'b1;
        return r;
    endfunction

    function automatic exp_t fetchExp(string tag, logic done);
        exp_t r = ex(tag, 4'd0, done ? (S_MRD | S_IRW | S_PCW) : S_MRD, 1'b0);
        r.val.iord = 1'b0; r.mask.iord = 1'b1;
        r.val.asa = 1'b0;  r.mask.asa = 1'b1;
        r.val.asb = 2'b01; r.mask.asb = '1;
        r.val.aop = 3'b010; r.mask.aop = '1;
        r.val.psrc = 2'b00; r.mask.psrc = '1;
        return r;
    endfunction

    function automatic exp_t decodeExp(string tag, logic ill);
        exp_t r = ex(tag, 4'd1, S_NONE, ill);
        r.val.asa = 1'b0; r.mask.asa = 1'b1;
        r.val.asb = 2'b11; r.mask.asb = '1;
        r.val.aop = 3'b010; r.mask.aop = '1;
        return r;
    endfunction

    task automatic push(input logic rst, input logic mr, input logic sd,
                        input logic [31:0] in, input exp_t ee);
        stim_t t;
        t.rst = rst; t.mr = mr; t.sd = sd; t.in = in;
        stimQ.push_back(t);
        expQ.push_back(ee);
    endtask

    task automatic apply(input stim_t t);
        @(negedge clk);
        reset = t.rst; mem_ready = t.mr; syscall_done = t.sd; inst = t.in;
        #1;
    endtask

    task automatic test_reset();
        exp_t r = ex("reset_hold", 4'd0, S_NONE, 1'b0);
        r.mask = '1;
        push(1, 1, 1, 32'h0, r);
        push(1, 1, 0, 32'h8D090004, r);
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_fetch_wait();
        push(0, 0, 0, 32'h0, fetchExp("fetch_wait1", 0));
        push(0, 0, 1, 32'h0, fetchExp("fetch_wait2_sd_ignored", 0));
        push(0, 0, 0, 32'h0, fetchExp("fetch_wait3", 0));
        push(0, 1, 0, 32'h0, fetchExp("fetch_done", 1));
        push(0, 0, 0, 32'h0, decodeExp("nop_decode", 0));
        push(0, 0, 0, 32'h0, fetchExp("nop_fast_back", 0));
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_lw();
        localparam logic [31:0] LW = 32'h8D090004;
        exp_t r;
        push(0, 1, 0, LW, fetchExp("lw_fetch", 1));
        push(0, 1, 0, LW, decodeExp("lw_decode", 0));
        r = ex("lw_memadr", 4'd2, S_NONE, 0);
        r.val.asa = 1; r.mask.asa = 1; r.val.asb = 2'b10; r.mask.asb = '1;
        r.val.aop = 3'b010; r.mask.aop = '1;
        push(0, 1, 0, LW, r);
        r = ex("lw_memrd", 4'd3, S_MRD, 0);
        r.val.iord = 1; r.mask.iord = 1;
        push(0, 1, 0, LW, r);
        r = ex("lw_memwb", 4'd4, S_RW, 0);
        r.val.rdst = 2'b00; r.mask.rdst = '1; r.val.m2r = 2'b01; r.mask.m2r = '1;
        push(0, 1, 0, LW, r);
        push(0, 0, 0, LW, fetchExp("lw_refetch", 0));
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_rtype();
        logic [31:0] insts [2] = '{32'h01095020, 32'h0109502A};
        logic [2:0]  ops   [2] = '{3'b010, 3'b111};
        exp_t r;
        for (int i = 0; i < 2; i++) begin
            push(0, 1, 0, insts[i], fetchExp("rt_fetch", 1));
            push(0, 0, 0, insts[i], decodeExp("rt_decode", 0));
            r = ex(i == 0 ? "add_ex" : "slt_ex", 4'd6, S_NONE, 0);
            r.val.asa = 1; r.mask.asa = 1; r.val.asb = 2'b00; r.mask.asb = '1;
            r.val.aop = ops[i]; r.mask.aop = '1;
            push(0, 0, 0, insts[i], r);
            r = ex(i == 0 ? "add_wb" : "slt_wb", 4'd7, S_RW, 0);
            r.val.rdst = 2'b01; r.mask.rdst = '1; r.val.m2r = 2'b00; r.mask.m2r = '1;
            push(0, 0, 0, insts[i], r);
        end
        push(0, 0, 0, 32'h0109502A, fetchExp("rt_refetch", 0));
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_branch_jal();
        logic [31:0] brs [2] = '{32'h15090003, 32'h11090003};
        exp_t r;
        for (int i = 0; i < 2; i++) begin
            push(0, 1, 0, brs[i], fetchExp("br_fetch", 1));
            push(0, 0, 0, brs[i], decodeExp("br_decode", 0));
            r = ex(i == 0 ? "bne_branch" : "beq_branch", 4'd8, S_PCWC, 0);
            r.val.bne = (i == 0); r.mask.bne = 1;
            r.val.aop = 3'b110; r.mask.aop = '1; r.val.psrc = 2'b01; r.mask.psrc = '1;
            r.val.asa = 1; r.mask.asa = 1; r.val.asb = 2'b00; r.mask.asb = '1;
            push(0, 0, 0, brs[i], r);
        end
        push(0, 1, 0, 32'h0C000010, fetchExp("jal_fetch", 1));
        push(0, 0, 0, 32'h0C000010, decodeExp("jal_decode", 0));
        r = ex("jal_exec", 4'd14, S_PCW | S_RW, 0);
        r.val.rdst = 2'b10; r.mask.rdst = '1; r.val.m2r = 2'b10; r.mask.m2r = '1;
        r.val.psrc = 2'b10; r.mask.psrc = '1;
        push(0, 0, 0, 32'h0C000010, r);
        push(0, 0, 0, 32'h0C000010, fetchExp("jal_refetch", 0));
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_syscall();
        localparam logic [31:0] SC = 32'h0000000C;
        push(0, 1, 0, SC, fetchExp("sc_fetch", 1));
        push(0, 0, 0, SC, decodeExp("sc_decode", 0));
        for (int i = 0; i < 5; i++)
            push(0, (i == 1), 0, SC, ex("sc_wait", 4'd12, S_SREQ, 0));
        push(0, 0, 1, SC, ex("sc_done", 4'd12, S_SREQ, 0));
        push(0, 0, 0, SC, fetchExp("sc_refetch", 0));
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_illegal();
        localparam logic [31:0] BAD = 32'hFC000000;
        push(0, 1, 0, BAD, fetchExp("ill_fetch", 1));
        push(0, 0, 0, BAD, decodeExp("ill_decode", 0));
        for (int i = 0; i < 4; i++)
            push(0, (i > 0), (i > 0), BAD, ex("ill_halt", 4'd15, S_NONE, 1));
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_back_to_back_sw_reset();
        localparam logic [31:0] SW = 32'hAD090004;
        exp_t r, z;
        z = ex("rst_clear", 4'd0, S_NONE, 0);
        z.mask = '1;
        push(1, 0, 0, SW, z);
        for (int i = 0; i < 2; i++) begin
            push(0, 1, 0, SW, fetchExp("sw_fetch", 1));
            push(0, 0, 0, SW, decodeExp("sw_decode", 0));
            r = ex("sw_memadr", 4'd2, S_NONE, 0);
            r.val.asa = 1; r.mask.asa = 1; r.val.asb = 2'b10; r.mask.asb = '1;
            push(0, 0, 0, SW, r);
            r = ex("sw_memwr", 4'd5, S_MWR, 0);
            r.val.iord = 1; r.mask.iord = 1;
            if (i == 0) begin
                push(0, 1, 0, SW, r);
                push(0, 0, 0, SW, fetchExp("sw_wr_dropped", 0));
            end else begin
                push(0, 0, 0, SW, r);
                push(0, 0, 0, SW, r);
                z.tag = "rst_mid_memwr";
                push(1, 1, 0, SW, z);
                push(0, 0, 0, SW, fetchExp("post_rst_fetch", 0));
            end
        end
        while (stimQ.size() != 0) begin
            s = stimQ.pop_front(); apply(s);
            e = expQ.pop_front(); got = obs(); checks++;
            if ((got & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", e.tag, got & e.mask, e.val & e.mask);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_fetch_wait();
        test_lw();
        test_rtype();
        test_branch_jal();
        test_syscall();
        test_illegal();
        test_back_to_back_sw_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
